// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter and pointer controller for a shared FIFO RAM.
// NREQ producers compete for the single RAM write port. A winner may keep
// the port for up to BURST consecutive beats before priority rotates. The
// block also owns the read/write pointers and the occupancy count.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no owner; a round-robin search from prio picks the next writer
// S_OWN  | owner holds the write port until its burst ends or req drops
//
// The grant is combinational so that a producer's word lands in the RAM in
// the same cycle it is requested. Flags and count follow one cycle later.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int AW    = 5,
    parameter int DW    = 8,
    parameter int BURST = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   din,
    input  logic                 rd,
    output logic [NREQ-1:0]      gnt,
    output logic                 wr_en,
    output logic [DW-1:0]        wr_data,
    output logic [AW-1:0]        wr_ptr,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_ptr,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 emp
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (BURST > 1) ? $clog2(BURST + 1) : 1;
    localparam logic [AW:0]   DEPTH     = {1'b1, {AW{1'b0}}};
    localparam logic [BW-1:0] BURST_LEN = BW'(BURST);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);

    typedef enum logic {
        S_IDLE,
        S_OWN
    } state_t;

    state_t          state;
    logic [IW-1:0]   prio;
    logic [IW-1:0]   owner;
    logic [BW-1:0]   beat;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [BW-1:0]   beat_nxt;

    // Wrap an index to the next producer in round-robin order.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == LAST_IDX)
            return '0;
        else
            return i + IW'(1);
    endfunction

    assign full  = (count == DEPTH);
    assign emp   = (count == '0);
    assign wr_en = |gnt;
    assign rd_en = rd & ~emp & ~rst;

    assign beat_nxt = beat + BW'(1);

    // Round-robin search: walk downward so the closest requester to prio wins last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(prio) + k) % NREQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant decode: the arbiter winner in IDLE, only the owner in OWN, nothing when full.
    always_comb begin
        gnt = '0;
        if (!rst && !full) begin
            if (state == S_IDLE) begin
                if (win_found)
                    gnt[win_idx] = 1'b1;
            end else if (req[owner]) begin
                gnt[owner] = 1'b1;
            end
        end
    end

    // Write-data mux; gnt is one-hot or zero so OR-ing the slices is safe.
    always_comb begin
        wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i])
                wr_data = wr_data | din[i*DW +: DW];
        end
    end

    // Pointers and occupancy; a simultaneous read and write leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Ownership FSM: start bursts, count beats, rotate priority when a burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            prio  <= '0;
            owner <= '0;
            beat  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!full && win_found) begin
                        if (BURST == 1) begin
                            prio <= next_idx(win_idx);
                        end else begin
                            state <= S_OWN;
                            owner <= win_idx;
                            beat  <= BW'(1);
                        end
                    end
                end
                S_OWN: begin
                    if (req[owner]) begin
                        // A full FIFO stalls the owner without losing the burst.
                        if (!full) begin
                            beat <= beat_nxt;
                            if (beat_nxt == BURST_LEN) begin
                                state <= S_IDLE;
                                prio  <= next_idx(owner);
                            end
                        end
                    end else begin
                        // Owner dropped its request: one bubble, then rotate.
                        state <= S_IDLE;
                        prio  <= next_idx(owner);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter and pointer controller that shares one 2^AW-entry FIFO memory among NREQ producers and one consumer. It grants the single write port to one producer per cycle, with bounded bursts. It muxes that producer's data onto the write bus and owns the read/write pointers and the occupancy count. It sits between the producer request lines and the dual-port FIFO RAM, which consumes wr_en/wr_ptr/wr_data and rd_en/rd_ptr.

Parameters:
NREQ, 4, number of producers (2..8)
AW, 5, pointer width; FIFO depth DEPTH = 2^AW
DW, 8, data width per producer
BURST, 2, max consecutive grants to one owner before rotating (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-producer write request, level
din  in  NREQ*DW  producer data, producer i at bits [i*DW +: DW]
rd  in  1  consumer read request
gnt  out  NREQ  one-hot write grant, combinational; producer i's data is written this cycle when gnt[i]=1
wr_en  out  1  RAM write strobe, = |gnt
wr_data  out  DW  din slice of granted producer; 0 when no grant
wr_ptr  out  AW  RAM write address
rd_en  out  1  RAM read strobe, = rd & ~emp & ~rst
rd_ptr  out  AW  RAM read address
count  out  AW+1  occupancy, 0..DEPTH
full  out  1  count == DEPTH
emp  out  1  count == 0

Behaviour:
- Reset (sync, rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0, prio=0, owner=0, beat=0, state=IDLE. While rst=1: gnt=0, wr_en=0, rd_en=0, wr_data=0. After reset: emp=1, full=0.
- Internal registers: state {IDLE, OWN}; prio (index of highest-priority requester); owner; beat (0..BURST).
- IDLE: if rst=0, full=0 and req!=0 -> winner = first i with req[i]=1, searching prio, prio+1, ... modulo NREQ. gnt[winner]=1.
  - If BURST=1: stay IDLE, prio <= winner+1 mod NREQ.
  - Else: state <= OWN, owner <= winner, beat <= 1.
  - If full=1 or req=0: no grant; registers hold.
- OWN:
  - req[owner]=1 and full=0: gnt[owner]=1, beat <= beat+1. If beat+1 == BURST: state <= IDLE, prio <= owner+1.
  - req[owner]=1 and full=1: stall. No grant, ownership kept, beat unchanged.
  - req[owner]=0: no grant this cycle (one bubble). state <= IDLE, prio <= owner+1.
  - Other requesters are never granted while in OWN.
- Pointers: wr_ptr += 1 on wr_en; rd_ptr += 1 on rd_en. Both wrap modulo DEPTH via natural AW-bit overflow.
- count update:
  - +1 if wr_en & ~rd_en
  - -1 if rd_en & ~wr_en
  - unchanged if both or neither
- Full: write blocked even when rd_en is asserted the same cycle; no write-through when full. Read on full is allowed.
- Empty: rd ignored (rd_en=0, rd_ptr holds). A write and a read in the same cycle on empty is not possible, since rd_en=0.
- Latency: grant and write occur in the same cycle as req (combinational). Flags and count reflect the write/read on the next cycle.
- Invariants (assert in bench):
  - gnt one-hot or zero
  - wr_en -> ~full
  - rd_en -> ~emp
  - count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers are equal and full
- Reset mid-burst discards ownership and all data: count=0, pointers 0.

Test Plan:
- Reset, then req=0, rd=0 for 5 cycles -> gnt=0, emp=1, full=0, count=0, wr_ptr=rd_ptr=0.
- NREQ=4, BURST=2, req=4'b1111 held, rd=0 -> grant order 0,0,1,1,2,2,3,3,0,0,... (one grant per cycle). After 32 grants: full=1, count=32, wr_ptr=0, gnt=0 thereafter.
- From full with owner=3 at beat=1 and req held, rd=1 for one cycle -> rd_en=1, count=31, rd_ptr=1. Next cycle gnt=4'b1000 (owner 3 completes burst), count=32; then gnt=0.
- count=5, req=4'b0100, rd=1 same cycle -> wr_en=1, rd_en=1, count stays 5, both pointers +1, wr_data=din[23:16].
- req=4'b0001 for 1 cycle then 4'b0010 -> cycle t gnt=0001, t+1 gnt=0000 (bubble, owner dropped), t+2 gnt=0010.
- count=10 mid-burst, rst=1 one cycle -> next cycle count=0, pointers 0, emp=1, gnt follows prio=0. rd=1 while emp -> rd_en=0, rd_ptr stays 0.
